// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage core: RAW forwarding selects, load-use stall and branch flush.
// Optional feature macro: HAZARD_FORWARDING_EN (undefined = no forwarding, stall until producer reaches W).
module hazard_unit #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_d,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   input  logic                  regwrite_d,
   input  logic                  load_d,
   input  logic                  pc_src_e,
   output logic [1:0]            fwd_a_e,
   output logic [1:0]            fwd_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e
);

   logic [REG_ADDR_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic                  regwrite_e, load_e, regwrite_m, regwrite_w;
   logic                  raw_stall;
   logic [1:0]            fwd_a, fwd_b;

   function automatic logic writes(input logic                  we,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] r);
      return we && (rd == r) && (r != '0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] r);
      if (writes(regwrite_m, rd_m, r))
         return 2'b10;
      else if (writes(regwrite_w, rd_w, r))
         return 2'b01;
      else
         return 2'b00;
   endfunction

`ifdef HAZARD_FORWARDING_EN
   always_comb begin
      fwd_a     = fwd_sel(rs1_e);
      fwd_b     = fwd_sel(rs2_e);
      raw_stall = valid_d && load_e &&
                  (writes(regwrite_e, rd_e, rs1_d) || writes(regwrite_e, rd_e, rs2_d));
   end
`else
   // Without forwarding the W stage and the E source fields only feed fwd_sel, which is unused.
   logic [1:0] unused_fwd;
   assign unused_fwd = fwd_sel(rs1_e) ^ fwd_sel(rs2_e) ^ {1'b0, load_e};

   always_comb begin
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
      raw_stall = valid_d &&
                  (writes(regwrite_e, rd_e, rs1_d) || writes(regwrite_e, rd_e, rs2_d) ||
                   writes(regwrite_m, rd_m, rs1_d) || writes(regwrite_m, rd_m, rs2_d));
   end
`endif

   // Reset overrides everything combinationally so a pending stall drops in the same cycle.
   always_comb begin
      fwd_a_e = 2'b00;
      fwd_b_e = 2'b00;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      if (!reset) begin
         fwd_a_e = fwd_a;
         fwd_b_e = fwd_b;
         stall_f = raw_stall && !pc_src_e;
         stall_d = raw_stall && !pc_src_e;
         flush_d = pc_src_e;
         flush_e = raw_stall || pc_src_e;
      end
   end

   // D -> E -> M -> W shadow pipeline; only the control bits are reset
   always_ff @(posedge clk) begin
      rs1_e <= rs1_d;
      rs2_e <= rs2_d;
      rd_e  <= rd_d;
      rd_m  <= rd_e;
      rd_w  <= rd_m;
      if (reset) begin
         regwrite_e <= 1'b0;
         load_e     <= 1'b0;
         regwrite_m <= 1'b0;
         regwrite_w <= 1'b0;
      end else begin
         regwrite_e <= valid_d && regwrite_d && !flush_e;
         load_e     <= valid_d && load_d && !flush_e;
         regwrite_m <= regwrite_e;
         regwrite_w <= regwrite_m;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed hazard scenarios plus randomized stream vs a stage-record model.
`timescale 1ns/1ps
module tb_hazard_unit;
   localparam int W = 5;

   logic         clk = 1'b0;
   logic         reset, valid_d, regwrite_d, load_d, pc_src_e;
   logic [W-1:0] rs1_d, rs2_d, rd_d;
   logic [1:0]   fwd_a_e, fwd_b_e;
   logic         stall_f, stall_d, flush_d, flush_e;
   logic [7:0]   obs;

   always #5 clk = ~clk;

   hazard_unit #(.REG_ADDR_W(W)) dut (
      .clk(clk), .reset(reset), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .regwrite_d(regwrite_d), .load_d(load_d), .pc_src_e(pc_src_e),
      .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .stall_f(stall_f), .stall_d(stall_d),
      .flush_d(flush_d), .flush_e(flush_e)
   );

   assign obs = {fwd_a_e, fwd_b_e, stall_f, stall_d, flush_d, flush_e};

   typedef struct {bit v; bit rw; bit ld; int unsigned rd; int unsigned rs1; int unsigned rs2;} ins_t;
   typedef struct {bit we; bit ld; int unsigned rd; int unsigned rs1; int unsigned rs2;} stg_t;

   stg_t me, mm, mw;
   int   checks = 0;
   int   errors = 0;

   function automatic ins_t mk(bit v, int unsigned a, int unsigned b, int unsigned d, bit rw, bit ld);
      ins_t i;
      i.v = v; i.rs1 = a; i.rs2 = b; i.rd = d; i.rw = rw; i.ld = ld;
      return i;
   endfunction

   function automatic bit wr(stg_t s, int unsigned r);
      return s.we && (s.rd == r) && (r != 0);
   endfunction

   // Expected {fwd_a, fwd_b, stall_f, stall_d, flush_d, flush_e} from the stage records.
   function automatic logic [7:0] exp_out();
      bit         hz;
      logic [1:0] fa, fb;
      if (reset) return 8'b0000_0011;
`ifdef HAZARD_FORWARDING_EN
      fa = wr(mm, me.rs1) ? 2'b10 : (wr(mw, me.rs1) ? 2'b01 : 2'b00);
      fb = wr(mm, me.rs2) ? 2'b10 : (wr(mw, me.rs2) ? 2'b01 : 2'b00);
      hz = valid_d && me.ld && (wr(me, rs1_d) || wr(me, rs2_d));
`else
      fa = 2'b00;
      fb = 2'b00;
      hz = valid_d && (wr(me, rs1_d) || wr(me, rs2_d) || wr(mm, rs1_d) || wr(mm, rs2_d));
`endif
      return {fa, fb, hz && !pc_src_e, hz && !pc_src_e, pc_src_e, hz || pc_src_e};
   endfunction

   task automatic present(ins_t i, bit pc);
      valid_d = i.v; rs1_d = i.rs1[W-1:0]; rs2_d = i.rs2[W-1:0]; rd_d = i.rd[W-1:0];
      regwrite_d = i.rw; load_d = i.ld; pc_src_e = pc;
      #1;
   endtask

   task automatic tick();
      logic [7:0] e;
      stg_t ne, nm, nw;
      e = exp_out();
      if (reset) begin
         ne = '{default: 0}; nm = ne; nw = ne;
      end else begin
         ne.we = valid_d && regwrite_d && !e[0];
         ne.ld = valid_d && load_d && !e[0];
         ne.rd = rd_d; ne.rs1 = rs1_d; ne.rs2 = rs2_d;
         nm = me; nw = mm;
      end
      @(posedge clk);
      me = ne; mm = nm; mw = nw;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [7:0] e;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         present(mk(1, 5, 5, 5, 1, 1), 1'b0);
         checks++;
         if (obs !== 8'b0000_0011) begin
            errors++; $display("FAIL reset_hold: got %b expected %b", obs, 8'b0000_0011);
         end
         tick();
      end
      reset = 1'b0;
      present(mk(0, 0, 0, 0, 0, 0), 1'b0);
      e = exp_out();
      checks++;
      if (obs !== 8'h00 || e !== 8'h00) begin
         errors++; $display("FAIL reset_release: got %b expected %b", obs, 8'h00);
      end
      tick();
   endtask

   task automatic test_alu_forward();
      ins_t seq[$];
      logic [7:0] e, lq[$];
      logic [3:0] fo = '0;
      int idx = 0, n = 0, nst = 0;
      seq.push_back(mk(1, 1, 2, 5, 1, 0));
      seq.push_back(mk(1, 5, 0, 8, 1, 0));
      seq.push_back(mk(1, 5, 3, 9, 1, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      while (idx < seq.size() && n < 16) begin
         present(seq[idx], 1'b0);
         e = exp_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL alu_fwd cyc%0d: got %b expected %b", n, obs, e); end
         lq.push_back(obs);
         fo |= obs[7:4];
         if (obs[2]) nst++;
         if (!e[2]) idx++;
         tick(); n++;
      end
`ifdef HAZARD_FORWARDING_EN
      checks++;
      if (lq[2][7:6] !== 2'b10) begin errors++; $display("FAIL alu_fwd_m: got %b expected 10", lq[2][7:6]); end
      checks++;
      if (lq[3][7:6] !== 2'b01) begin errors++; $display("FAIL alu_fwd_w: got %b expected 01", lq[3][7:6]); end
      checks++;
      if (nst != 0) begin errors++; $display("FAIL alu_fwd_stalls: got %0d expected 0", nst); end
`else
      checks++;
      if (nst != 2) begin errors++; $display("FAIL alu_raw_stalls: got %0d expected 2", nst); end
      checks++;
      if (fo !== 4'b0000) begin errors++; $display("FAIL alu_raw_fwd: got %b expected 0000", fo); end
`endif
   endtask

   task automatic test_load_use();
      ins_t seq[$];
      logic [7:0] e, lq[$];
      int idx = 0, n = 0, nst = 0;
      seq.push_back(mk(1, 1, 0, 6, 1, 1));
      seq.push_back(mk(1, 2, 6, 10, 1, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      while (idx < seq.size() && n < 16) begin
         present(seq[idx], 1'b0);
         e = exp_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL load_use cyc%0d: got %b expected %b", n, obs, e); end
         lq.push_back(obs);
         if (obs[2]) nst++;
         if (!e[2]) idx++;
         tick(); n++;
      end
      checks++;
      if (lq[1][3:0] !== 4'b1101) begin errors++; $display("FAIL load_use_stall: got %b expected 1101", lq[1][3:0]); end
`ifdef HAZARD_FORWARDING_EN
      checks++;
      if (nst != 1) begin errors++; $display("FAIL load_use_len: got %0d expected 1", nst); end
      checks++;
      if (lq[3][5:4] !== 2'b01) begin errors++; $display("FAIL load_use_fwd_b: got %b expected 01", lq[3][5:4]); end
`else
      checks++;
      if (nst != 2) begin errors++; $display("FAIL load_use_len: got %0d expected 2", nst); end
`endif
   endtask

   task automatic test_x0();
      ins_t seq[$];
      logic [7:0] e, acc = '0;
      int n = 0;
      seq.push_back(mk(1, 1, 2, 0, 1, 0));
      seq.push_back(mk(1, 0, 0, 11, 1, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      foreach (seq[k]) begin
         present(seq[k], 1'b0);
         e = exp_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL x0 cyc%0d: got %b expected %b", n, obs, e); end
         acc |= obs;
         tick(); n++;
      end
      checks++;
      if (acc !== 8'h00) begin errors++; $display("FAIL x0_quiet: got %b expected %b", acc, 8'h00); end
   endtask

   task automatic test_m_priority();
      ins_t seq[$];
      logic [7:0] e, lq[$];
      logic [3:0] fo = '0;
      int idx = 0, n = 0, nst = 0;
      seq.push_back(mk(1, 1, 0, 7, 1, 0));
      seq.push_back(mk(1, 1, 0, 7, 1, 0));
      seq.push_back(mk(1, 7, 0, 12, 1, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      seq.push_back(mk(0, 0, 0, 0, 0, 0));
      while (idx < seq.size() && n < 16) begin
         present(seq[idx], 1'b0);
         e = exp_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL m_prio cyc%0d: got %b expected %b", n, obs, e); end
         lq.push_back(obs);
         fo |= obs[7:4];
         if (obs[2]) nst++;
         if (!e[2]) idx++;
         tick(); n++;
      end
`ifdef HAZARD_FORWARDING_EN
      checks++;
      if (lq[3][7:6] !== 2'b10) begin errors++; $display("FAIL m_prio_sel: got %b expected 10", lq[3][7:6]); end
`else
      checks++;
      if (nst != 2) begin errors++; $display("FAIL m_prio_stalls: got %0d expected 2", nst); end
      checks++;
      if (fo !== 4'b0000) begin errors++; $display("FAIL m_prio_fwd: got %b expected 0000", fo); end
`endif
   endtask

   task automatic test_branch_load();
      logic [7:0] e;
      present(mk(1, 1, 0, 6, 1, 1), 1'b0);
      tick();
      present(mk(1, 2, 6, 10, 1, 0), 1'b1);
      e = exp_out();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL branch_load_model: got %b expected %b", obs, e); end
      checks++;
      if (obs[3:0] !== 4'b0011) begin errors++; $display("FAIL branch_load_ctl: got %b expected 0011", obs[3:0]); end
      tick();
      present(mk(0, 0, 0, 0, 0, 0), 1'b0);
      e = exp_out();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL branch_after: got %b expected %b", obs, e); end
      tick();
      present(mk(0, 0, 0, 0, 0, 0), 1'b0);
      tick();
   endtask

   task automatic test_reset_mid_stall();
      logic [7:0] e;
      present(mk(1, 1, 0, 6, 1, 1), 1'b0);
      tick();
      present(mk(1, 6, 0, 13, 1, 0), 1'b0);
      checks++;
      if (obs[3:0] !== 4'b1101) begin errors++; $display("FAIL pre_reset_stall: got %b expected 1101", obs[3:0]); end
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== 8'b0000_0011) begin errors++; $display("FAIL reset_mid_stall: got %b expected %b", obs, 8'b0000_0011); end
      tick();
      reset = 1'b0;
      present(mk(0, 0, 0, 0, 0, 0), 1'b0);
      e = exp_out();
      checks++;
      if (obs !== 8'h00 || e !== 8'h00) begin errors++; $display("FAIL post_reset: got %b expected %b", obs, 8'h00); end
      tick();
   endtask

   task automatic test_random();
      ins_t cur;
      logic [7:0] e;
      bit held = 0;
      for (int n = 0; n < 400; n++) begin
         if (!held)
            cur = mk($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
         reset = ($urandom_range(0, 49) == 0);
         present(cur, $urandom_range(0, 9) == 0);
         e = exp_out();
         checks++;
         if (obs !== e) begin errors++; $display("FAIL random cyc%0d: got %b expected %b", n, obs, e); end
         held = e[2];
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      me = '{default: 0}; mm = me; mw = me;
      reset = 1'b1; valid_d = 0; rs1_d = '0; rs2_d = '0; rd_d = '0;
      regwrite_d = 0; load_d = 0; pc_src_e = 0;
      @(negedge clk);
      test_reset();
      test_alu_forward();
      test_load_use();
      test_x0();
      test_m_priority();
      test_branch_load();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
